// File: rtl/mult_err_pkg.sv
// Shared definitions for the approximate-multiplier error accumulator.
//   ED_W         : width of an error distance (full 8x8 product width)
//   CNT_W        : width of the sample and error counters
//   DEF_SAMPLES  : default samples per run
//   DEF_SUM_W    : default width of the error-distance sum
//   state_t      : run-control FSM encoding
package mult_err_pkg;

  localparam int ED_W        = 16;
  localparam int CNT_W       = 16;
  localparam int DEF_SAMPLES = 256;
  localparam int DEF_SUM_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/err_dist.sv
// Combinational absolute difference of two unsigned ED_W-bit values.
//   a, b : operands (exact product, approximate product)
//   d    : |a - b|
module err_dist
  import mult_err_pkg::*;
(
  input  logic [ED_W-1:0] a,
  input  logic [ED_W-1:0] b,
  output logic [ED_W-1:0] d
);

  assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/mult_8x8_err_acc.sv
// Error-distance accumulator for an external approximate 8x8 multiplier.
// A and B are fanned out to the multiplier, which returns R in the same cycle.
// Each accepted sample is compared against the exact product, and the block
// gathers the sum, maximum and nonzero count of |A*B - R| over SAMPLES samples.
//   clk, rst          : clock, synchronous active-high reset
//   start             : pulse that begins a run (ignored while busy)
//   in_valid/in_ready : sample handshake for A, B, R
//   A, B, R           : operands and approximate product
//   busy, done        : run in progress / results final (held until start)
//   sum_ed            : saturating error-distance sum, with sat as the sticky flag
//   max_ed, err_cnt   : largest error distance / count of nonzero errors
module mult_8x8_err_acc
  import mult_err_pkg::*;
#(
  parameter int SAMPLES = DEF_SAMPLES,
  parameter int SUM_W   = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [15:0]      R,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_ed,
  output logic [ED_W-1:0]  max_ed,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sat
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept, last_acc, run_start;

  // Stage 1 registers.
  logic             s1_vld;
  logic [ED_W-1:0]  s1_exact, s1_r;

  // Stage 2 combinational results.
  logic [ED_W-1:0]  ed;
  logic [SUM_W:0]   sum_nxt;

  assign accept    = in_valid && in_ready;
  assign last_acc  = accept && (acc_cnt == CNT_W'(SAMPLES - 1));
  assign run_start = start && ((state == IDLE) || (state == DONE));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_acc) state_nxt = DRAIN;
      // The last sample was accumulated on the edge that cleared s1_vld.
      DRAIN:   if (!s1_vld) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == RUN) && (acc_cnt < CNT_W'(SAMPLES));
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
  end

  err_dist u_err_dist (
    .a (s1_exact),
    .b (s1_r),
    .d (ed)
  );

  // One extra carry bit detects overflow of the sum.
  assign sum_nxt = {1'b0, sum_ed} + (SUM_W + 1)'(ed);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_exact <= '0;
      s1_r     <= '0;
      acc_cnt  <= '0;
      sum_ed   <= '0;
      max_ed   <= '0;
      err_cnt  <= '0;
      sat      <= 1'b0;
    end else begin
      // Stage 1: capture the exact product alongside the returned R.
      s1_vld <= accept;
      if (accept) begin
        s1_exact <= ED_W'(A) * ED_W'(B);
        s1_r     <= R;
      end

      if (run_start) begin
        // s1_vld is always clear in IDLE/DONE, so nothing is lost here.
        acc_cnt <= '0;
        sum_ed  <= '0;
        max_ed  <= '0;
        err_cnt <= '0;
        sat     <= 1'b0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + 1'b1;

        // Stage 2: accumulate.
        if (s1_vld) begin
          if (sum_nxt[SUM_W]) begin
            sum_ed <= '1;
            sat    <= 1'b1;
          end else begin
            sum_ed <= sum_nxt[SUM_W-1:0];
          end
          if (ed > max_ed) max_ed <= ed;
          if ((ed != '0) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_8x8_err_acc.sv
// Directed bench for mult_8x8_err_acc. It uses three instances with different
// SAMPLES/SUM_W settings, shares the sample inputs among them, and gives each
// instance its own start. A behavioural model pushes the expected result of
// each run into a queue. The queue entry is popped and compared when done is due.
module tb_mult_8x8_err_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  A, B;
  logic [15:0] R;
  logic [2:0]  start_v;

  logic [2:0]  rdy, bsy, dn, st;
  logic [15:0] mx [3];
  logic [15:0] cn [3];
  logic [31:0] sum0, sum1;
  logic [16:0] sum2;

  always #5 clk = ~clk;

  mult_8x8_err_acc #(.SAMPLES(4), .SUM_W(32)) u_s4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .A(A), .B(B), .R(R), .busy(bsy[0]), .done(dn[0]), .sum_ed(sum0),
    .max_ed(mx[0]), .err_cnt(cn[0]), .sat(st[0]));

  mult_8x8_err_acc #(.SAMPLES(3), .SUM_W(32)) u_s3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .A(A), .B(B), .R(R), .busy(bsy[1]), .done(dn[1]), .sum_ed(sum1),
    .max_ed(mx[1]), .err_cnt(cn[1]), .sat(st[1]));

  mult_8x8_err_acc #(.SAMPLES(3), .SUM_W(17)) u_s3n (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .A(A), .B(B), .R(R), .busy(bsy[2]), .done(dn[2]), .sum_ed(sum2),
    .max_ed(mx[2]), .err_cnt(cn[2]), .sat(st[2]));

  // Observed outputs of the selected instance
  int          sel;
  logic        o_rdy, o_bsy, o_dn, o_sat;
  logic [47:0] o_sum;
  logic [15:0] o_max, o_cnt;

  always_comb begin
    o_rdy = rdy[0]; o_bsy = bsy[0]; o_dn = dn[0]; o_sat = st[0];
    o_sum = 48'(sum0); o_max = mx[0]; o_cnt = cn[0];
    case (sel)
      1: begin
        o_rdy = rdy[1]; o_bsy = bsy[1]; o_dn = dn[1]; o_sat = st[1];
        o_sum = 48'(sum1); o_max = mx[1]; o_cnt = cn[1];
      end
      2: begin
        o_rdy = rdy[2]; o_bsy = bsy[2]; o_dn = dn[2]; o_sat = st[2];
        o_sum = 48'(sum2); o_max = mx[2]; o_cnt = cn[2];
      end
      default: ;
    endcase
  end

  typedef struct {
    longint sum;
    int     mx;
    int     cnt;
    bit     sat;
  } res_t;

  res_t sbq[$];

  int checks   = 0;
  int failures = 0;

  // Model state: m_state 0 = idle, 1 = run/drain, 2 = done
  int     m_state, m_samples, m_sumw, m_acc, m_max, m_cnt;
  longint m_sum;
  bit     m_sat;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m_sum = 0; m_max = 0; m_cnt = 0; m_sat = 0; m_acc = 0;
  endtask

  task automatic m_sample(input int a, input int b, input int r);
    int     exact, ed;
    longint lim;
    exact = a * b;
    ed    = (exact > r) ? exact - r : r - exact;
    lim   = (longint'(1) << m_sumw) - 1;
    if (m_sum + ed > lim) begin
      m_sum = lim;
      m_sat = 1;
    end else begin
      m_sum = m_sum + ed;
    end
    if (ed > m_max) m_max = ed;
    if (ed != 0 && m_cnt < 65535) m_cnt++;
  endtask

  // Called #1 after the last accept edge. done must rise exactly two edges later.
  task automatic finish_run();
    res_t e;
    in_valid = 1'b0;
    chk("done_acc0", 48'(o_dn), 48'(0));
    chk("ready_after_last", 48'(o_rdy), 48'(0));
    @(posedge clk); #1;
    chk("done_acc1", 48'(o_dn), 48'(0));
    chk("busy_drain", 48'(o_bsy), 48'(1));
    @(posedge clk); #1;
    chk("done_acc2", 48'(o_dn), 48'(1));
    chk("busy_done", 48'(o_bsy), 48'(0));
    e = sbq.pop_front();
    chk("sum_ed", o_sum, 48'(e.sum));
    chk("max_ed", 48'(o_max), 48'(e.mx));
    chk("err_cnt", 48'(o_cnt), 48'(e.cnt));
    chk("sat", 48'(o_sat), 48'(e.sat));
    m_state = 2;
  endtask

  task automatic step(input bit v, input int a, input int b, input int r);
    bit exp_rdy;
    res_t e;
    @(negedge clk);
    exp_rdy = (m_state == 1) && (m_acc < m_samples);
    chk("in_ready", 48'(o_rdy), 48'(exp_rdy));
    in_valid = v; A = 8'(a); B = 8'(b); R = 16'(r);
    @(posedge clk); #1;
    if (v && exp_rdy) begin
      m_sample(a, b, r);
      m_acc++;
      if (m_acc == m_samples) begin
        e.sum = m_sum; e.mx = m_max; e.cnt = m_cnt; e.sat = m_sat;
        sbq.push_back(e);
        finish_run();
      end
    end
  endtask

  task automatic pulse_start(input int s);
    @(negedge clk);
    sel = s;
    start_v[s] = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start_v = '0;
    if (m_state != 1) begin
      m_clear();
      m_state   = 1;
      m_samples = (s == 0) ? 4 : 3;
      m_sumw    = (s == 2) ? 17 : 32;
      chk("clr_sum", o_sum, 48'(0));
      chk("clr_max", 48'(o_max), 48'(0));
      chk("clr_cnt", 48'(o_cnt), 48'(0));
      chk("clr_sat", 48'(o_sat), 48'(0));
    end
    chk("start_busy", 48'(o_bsy), 48'(1));
    chk("start_done", 48'(o_dn), 48'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sum"}, o_sum, 48'(0));
    chk({tag, "_max"}, 48'(o_max), 48'(0));
    chk({tag, "_cnt"}, 48'(o_cnt), 48'(0));
    chk({tag, "_sat"}, 48'(o_sat), 48'(0));
    chk({tag, "_busy"}, 48'(o_bsy), 48'(0));
    chk({tag, "_done"}, 48'(o_dn), 48'(0));
    chk({tag, "_rdy"}, 48'(o_rdy), 48'(0));
  endtask

  initial begin
    int a, b;
    int da[4], db[4], dr[4];
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; R = '0; start_v = '0;
    sel = 0; m_state = 0; m_samples = 4; m_sumw = 32; m_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_zero("reset");
    end
    rst = 1'b0;

    // Exact multiplier and random operands: no error at all
    pulse_start(0);
    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
      step(1, a, b, a * b);
    end

    // Mixed errors: a large one, a small one, and an exact sample
    pulse_start(1);
    step(1, 255, 255, 0);
    step(1, 3, 5, 14);
    step(1, 2, 2, 4);

    // Start in DONE clears the results. A start pulse in RUN is ignored.
    pulse_start(1);
    step(1, 10, 10, 90);
    pulse_start(1);
    step(1, 7, 9, 70);
    step(1, 200, 100, 20000);

    // Narrow sum saturates
    pulse_start(2);
    for (int i = 0; i < 3; i++) step(1, 255, 255, 0);

    // Gap-free run, then the same data with in_valid gaps
    for (int i = 0; i < 4; i++) begin
      da[i] = int'($urandom_range(0, 255)); db[i] = int'($urandom_range(0, 255));
      dr[i] = int'($urandom_range(0, 65535));
    end
    pulse_start(0);
    for (int i = 0; i < 4; i++) step(1, da[i], db[i], dr[i]);
    pulse_start(0);
    step(1, da[0], db[0], dr[0]);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, da[1], db[1], dr[1]);
    step(0, 0, 0, 0);
    step(1, da[2], db[2], dr[2]);
    step(1, da[3], db[3], dr[3]);

    // Reset mid-run has priority over start and in_valid
    pulse_start(0);
    step(1, 255, 255, 1);
    step(1, 100, 100, 0);
    @(negedge clk);
    rst = 1'b1; start_v[0] = 1'b1; in_valid = 1'b1; A = 8'd50; B = 8'd50; R = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0; start_v = '0; in_valid = 1'b0;
    m_state = 0; m_clear();
    check_zero("midrst");
    pulse_start(0);
    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
      step(1, a, b, a * b);
    end

    chk("sb_empty", 48'(sbq.size()), 48'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
